sap1_controller_sequencer: RTL and testbench

Control sequencer for the SAP-1 computer. A one-hot six-state ring counter (T1–T6) decodes the 4-bit opcode from the instruction register and generates the 12-bit control word for the datapath. The control word drives the 4-bit program counter's enable and output, the MAR, RAM, IR, the A and B registers, the adder/subtractor and the output register. It also latches HLT.

---
 rtl/sap1_controller_sequencer.sv | 129 ++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control sequencer: six-state one-hot ring clocked on the falling edge,
// with combinational decode of ring, opcode and halt into the datapath control word.
module sap1_controller_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       halted,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       b_load,
    output logic       out_load
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    ring_t ring_q, ring_d;
    logic  halted_q, halted_d;
    logic  advance;

    // Falling-edge update keeps the control word stable across the datapath's rising edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            ring_q   <= T1;
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    assign advance = enable && !halted_q;

    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        pc_inc   = 1'b0;
        pc_out   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        alu_sub  = 1'b0;
        alu_out  = 1'b0;
        b_load   = 1'b0;
        out_load = 1'b0;

        case (ring_q)
            T1: if (advance) ring_d = T2;
            T2: if (advance) ring_d = T3;
            T3: if (advance) ring_d = T4;
            T4: if (advance) begin
                    if (opcode == OP_HLT) halted_d = 1'b1;
                    else                  ring_d   = T5;
                end
            T5: if (advance) ring_d = T6;
            T6: if (advance) ring_d = T1;
            default: ring_d = T1;
        endcase

        if (!halted_q) begin
            case (ring_q)
                T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tstate = ring_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Self-checking bench for sap1_controller_sequencer: directed instruction walks
// followed by randomized opcode/enable/reset traffic against a state-index model.
module tb_sap1_controller_sequencer;

    logic       clock = 1'b1;
    logic       reset;
    logic       enable;
    logic [3:0] opcode;
    logic [5:0] tstate;
    logic       halted;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, alu_sub, alu_out, b_load, out_load;

    sap1_controller_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .opcode   (opcode),
        .tstate   (tstate),
        .halted   (halted),
        .pc_inc   (pc_inc),
        .pc_out   (pc_out),
        .mar_load (mar_load),
        .ram_out  (ram_out),
        .ir_load  (ir_load),
        .ir_out   (ir_out),
        .a_load   (a_load),
        .a_out    (a_out),
        .alu_sub  (alu_sub),
        .alu_out  (alu_out),
        .b_load   (b_load),
        .out_load (out_load)
    );

    always #5 clock = ~clock;

    localparam logic [11:0] C_PC_INC   = 12'h800;
    localparam logic [11:0] C_PC_OUT   = 12'h400;
    localparam logic [11:0] C_MAR_LOAD = 12'h200;
    localparam logic [11:0] C_RAM_OUT  = 12'h100;
    localparam logic [11:0] C_IR_LOAD  = 12'h080;
    localparam logic [11:0] C_IR_OUT   = 12'h040;
    localparam logic [11:0] C_A_LOAD   = 12'h020;
    localparam logic [11:0] C_A_OUT    = 12'h010;
    localparam logic [11:0] C_ALU_SUB  = 12'h008;
    localparam logic [11:0] C_ALU_OUT  = 12'h004;
    localparam logic [11:0] C_B_LOAD   = 12'h002;
    localparam logic [11:0] C_OUT_LOAD = 12'h001;

    int checks   = 0;
    int failures = 0;
    int m_t      = 0;   // model state index: 0 = T1 ... 5 = T6
    bit m_h      = 1'b0;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_word(input int t, input logic [3:0] op, input bit h);
        logic [11:0] w;
        w = 12'h000;
        if (!h) begin
            case (t)
                0: w = C_PC_OUT | C_MAR_LOAD;
                1: w = C_PC_INC;
                2: w = C_RAM_OUT | C_IR_LOAD;
                3: if (op <= 4'd2) w = C_IR_OUT | C_MAR_LOAD;
                   else if (op == 4'd14) w = C_A_OUT | C_OUT_LOAD;
                4: if (op == 4'd0) w = C_RAM_OUT | C_A_LOAD;
                   else if (op == 4'd1 || op == 4'd2) w = C_RAM_OUT | C_B_LOAD;
                5: if (op == 4'd1) w = C_ALU_OUT | C_A_LOAD;
                   else if (op == 4'd2) w = C_ALU_SUB | C_ALU_OUT | C_A_LOAD;
                default: w = 12'h000;
            endcase
        end
        return w;
    endfunction

    task automatic check_all(input string tag);
        logic [11:0] word;
        logic [5:0]  exp_t;
        word  = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, alu_sub, alu_out, b_load, out_load};
        exp_t = 6'd1 << m_t;
        check({tag, "_tstate"}, 12'(tstate), 12'(exp_t));
        check({tag, "_onehot"}, 12'($onehot(tstate)), 12'd1);
        check({tag, "_halted"}, 12'(halted), 12'(m_h));
        check({tag, "_ctrl"}, word, exp_word(m_t, opcode, m_h));
    endtask

    // One full clock: model follows the falling edge, outputs sampled mid-cycle.
    task automatic tick(input string tag);
        @(negedge clock);
        if (!reset && enable && !m_h) begin
            if (m_t == 3 && opcode == 4'hF) m_h = 1'b1;
            else                            m_t = (m_t + 1) % 6;
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Called at posedge+1; changes inputs at posedge+2, well away from the falling edge.
    task automatic drive(input logic rst, input logic en, input logic [3:0] op);
        #1;
        reset  = rst;
        enable = en;
        opcode = op;
        if (rst) begin
            m_t = 0;
            m_h = 1'b0;
            #1;
            check_all("async_reset");
        end
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        opcode = 4'h0;
        #3;
        check_all("reset");
        @(posedge clock);
        #1;

        drive(1'b0, 1'b1, 4'h0);
        ticks(4, "lda_fetch");
        drive(1'b1, 1'b1, 4'h0);          // reset in the middle of LDA T5
        drive(1'b0, 1'b1, 4'h1);
        ticks(6, "add");
        drive(1'b0, 1'b1, 4'h2);
        ticks(6, "sub");
        drive(1'b0, 1'b1, 4'hE);
        ticks(6, "out");
        drive(1'b0, 1'b1, 4'h7);
        ticks(6, "undef");
        drive(1'b0, 1'b1, 4'h0);
        ticks(2, "to_t3");
        drive(1'b0, 1'b0, 4'h0);
        ticks(5, "pause_t3");
        drive(1'b0, 1'b1, 4'h0);
        ticks(4, "resume");
        drive(1'b0, 1'b1, 4'hF);
        ticks(4, "hlt");
        ticks(22, "halted_hold");
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b0, 1'b1, 4'h0);
        ticks(3, "after_halt");

        for (int i = 0; i < 400; i++) begin
            logic       rst;
            logic       en;
            logic [3:0] op;
            rst = ($urandom_range(0, 39) == 0) || (m_h && $urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 7) != 0);
            op  = opcode;
            if (m_t == 0 || $urandom_range(0, 15) == 0) op = 4'($urandom_range(0, 15));
            drive(rst, en, op);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
